pc_target_unit: RTL and testbench

//   Registered program counter and next-address generator for the 8-bit CPU datapath.

---
 rtl/pc_target_unit_if.sv | 28 ++
 rtl/pc_target_unit.sv | 125 ++++++++++++
 tb/tb_pc_target_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_target_unit_if.sv
// Decode-side control bundle and PC/stack status for pc_target_unit.
// master = instruction decode, slave = PC unit.
interface pc_target_unit_if #(
  parameter int ADDR_W = 8,
  parameter int PAGE_W = 3
);
  localparam int TGT_W = ADDR_W - PAGE_W;

  logic              en;
  logic [1:0]        op;
  logic [TGT_W-1:0]  target;
  logic              br_taken;
  logic              call;
  logic [ADDR_W-1:0] pc;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;

  modport master (
    output en, op, target, br_taken, call,
    input  pc, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  en, op, target, br_taken, call,
    output pc, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/pc_target_unit.sv
// Registered PC with INC / in-page JMP / relative BR / RET next-address select.
// Define CALL_STACK_EN to build the return-address stack and stack_err.
module pc_target_unit #(
  parameter int ADDR_W      = 8,
  parameter int PAGE_W      = 3,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_VEC   = 0
) (
  input  logic               clk,
  input  logic               rst,
  pc_target_unit_if.slave    bus
);
  localparam int TGT_W = ADDR_W - PAGE_W;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_JMP = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_RET = 2'b11;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] p1;
  logic [ADDR_W-1:0] jmp_pc;
  logic [ADDR_W-1:0] br_pc;

  assign p1     = pc_q + 1'b1;
  assign jmp_pc = {pc_q[ADDR_W-1 -: PAGE_W], bus.target};
  assign br_pc  = p1 + {{PAGE_W{bus.target[TGT_W-1]}}, bus.target};

`ifdef CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stk_d [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d;
  logic              full, empty;
  logic [IDX_W-1:0]  push_idx, top_idx;

  assign full     = (sp_q == SP_W'(STACK_DEPTH));
  assign empty    = (sp_q == '0);
  assign push_idx = IDX_W'(sp_q);
  assign top_idx  = IDX_W'(sp_q - 1'b1);

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    stk_d = stk_q;
    if (bus.en) begin
      unique case (bus.op)
        OP_INC: pc_d = p1;
        OP_JMP: begin
          pc_d = jmp_pc;
          if (bus.call) begin
            // A push into a full stack is dropped; the jump still goes.
            if (full) begin
              err_d = 1'b1;
            end else begin
              stk_d[push_idx] = p1;
              sp_d = sp_q + 1'b1;
            end
          end
        end
        OP_BR:  pc_d = bus.br_taken ? br_pc : p1;
        OP_RET: begin
          if (empty) begin
            pc_d  = p1;
            err_d = 1'b1;
          end else begin
            pc_d = stk_q[top_idx];
            sp_d = sp_q - 1'b1;
          end
        end
        default: pc_d = p1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= ADDR_W'(RESET_VEC);
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    stk_q <= stk_d;
  end

  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_q;
`else
  logic unused_call;
  assign unused_call = bus.call;

  always_comb begin
    pc_d = pc_q;
    if (bus.en) begin
      unique case (bus.op)
        OP_JMP:  pc_d = jmp_pc;
        OP_BR:   pc_d = bus.br_taken ? br_pc : p1;
        default: pc_d = p1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= ADDR_W'(RESET_VEC);
    else     pc_q <= pc_d;
  end

  assign bus.stack_full  = 1'b0;
  assign bus.stack_empty = 1'b1;
  assign bus.stack_err   = 1'b0;
`endif

  assign bus.pc = pc_q;
endmodule

// File: tb/tb_pc_target_unit.sv
// Directed bench for pc_target_unit; covers both CALL_STACK_EN builds.
// Inputs change #1 after posedge; outputs checked #1 after the next posedge.
module tb_pc_target_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;

  pc_target_unit_if #(.ADDR_W(8), .PAGE_W(3)) bus ();

  pc_target_unit #(
    .ADDR_W(8), .PAGE_W(3), .STACK_DEPTH(4), .RESET_VEC(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic e, input logic [1:0] o,
                      input logic [4:0] t, input logic b,
                      input logic c);
    bus.en = e; bus.op = o; bus.target = t;
    bus.br_taken = b; bus.call = c;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 2'b00, 5'h00, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Navigate with +16 branches to the page, then in-page jump.
  task automatic goto_pc(input logic [7:0] a);
    for (int i = 0; i < 20; i++) begin
      if (bus.pc[7:5] == a[7:5]) break;
      tick(1'b1, 2'b10, 5'h0F, 1'b1, 1'b0);
    end
    tick(1'b1, 2'b01, a[4:0], 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.pc !== 8'h00 || bus.stack_empty !== 1'b1 ||
        bus.stack_full !== 1'b0 || bus.stack_err !== 1'b0) begin
      bad++;
      $display("FAIL reset pc=%h e=%b f=%b err=%b exp 00 1 0 0",
               bus.pc, bus.stack_empty, bus.stack_full, bus.stack_err);
    end
  endtask

  task automatic test_inc();
    logic [7:0] exp_pc [3];
    exp_pc[0] = 8'h01; exp_pc[1] = 8'h02; exp_pc[2] = 8'h03;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 2'b00, 5'h00, 1'b0, 1'b0);
      total++;
      if (bus.pc !== exp_pc[i]) begin
        bad++;
        $display("FAIL inc%0d pc=%h exp=%h", i, bus.pc, exp_pc[i]);
      end
    end
    goto_pc(8'hFF);
    total++;
    if (bus.pc !== 8'hFF) begin
      bad++; $display("FAIL goto_ff pc=%h exp=ff", bus.pc);
    end
    tick(1'b1, 2'b00, 5'h00, 1'b0, 1'b0);
    total++;
    if (bus.pc !== 8'h00) begin
      bad++; $display("FAIL inc_wrap pc=%h exp=00", bus.pc);
    end
  endtask

  task automatic test_jmp();
    goto_pc(8'h47);
    tick(1'b1, 2'b01, 5'h1C, 1'b0, 1'b0);
    total++;
    if (bus.pc !== 8'h5C) begin
      bad++; $display("FAIL jmp_page pc=%h exp=5c", bus.pc);
    end
    goto_pc(8'h5F);
    tick(1'b1, 2'b01, 5'h00, 1'b0, 1'b0);
    total++;
    if (bus.pc !== 8'h40) begin
      bad++; $display("FAIL jmp_last pc=%h exp=40", bus.pc);
    end
  endtask

  task automatic test_br();
    goto_pc(8'h10);
    tick(1'b1, 2'b10, 5'h1E, 1'b1, 1'b0);
    total++;
    if (bus.pc !== 8'h0F) begin
      bad++; $display("FAIL br_neg pc=%h exp=0f", bus.pc);
    end
    goto_pc(8'h10);
    tick(1'b1, 2'b10, 5'h1E, 1'b0, 1'b0);
    total++;
    if (bus.pc !== 8'h11) begin
      bad++; $display("FAIL br_not pc=%h exp=11", bus.pc);
    end
    goto_pc(8'hFE);
    tick(1'b1, 2'b10, 5'h03, 1'b1, 1'b0);
    total++;
    if (bus.pc !== 8'h02) begin
      bad++; $display("FAIL br_wrap pc=%h exp=02", bus.pc);
    end
  endtask

  task automatic test_calls();
    logic [7:0] from [4];
    logic [7:0] ret_pc [4];
    from[0] = 8'h03; from[1] = 8'h23; from[2] = 8'h43; from[3] = 8'h63;
    ret_pc[0] = 8'h64; ret_pc[1] = 8'h44;
    ret_pc[2] = 8'h24; ret_pc[3] = 8'h04;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      goto_pc(from[i]);
      tick(1'b1, 2'b01, 5'h03, 1'b0, 1'b1);
    end
`ifdef CALL_STACK_EN
    total++;
    if (bus.stack_full !== 1'b1 || bus.stack_err !== 1'b0) begin
      bad++;
      $display("FAIL calls_full f=%b err=%b exp 1 0",
               bus.stack_full, bus.stack_err);
    end
    tick(1'b1, 2'b01, 5'h10, 1'b0, 1'b1);
    total++;
    if (bus.pc !== 8'h70 || bus.stack_err !== 1'b1) begin
      bad++;
      $display("FAIL overflow pc=%h err=%b exp 70 1",
               bus.pc, bus.stack_err);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 2'b11, 5'h00, 1'b0, 1'b0);
      total++;
      if (bus.pc !== ret_pc[i]) begin
        bad++;
        $display("FAIL ret%0d pc=%h exp=%h", i, bus.pc, ret_pc[i]);
      end
    end
    total++;
    if (bus.stack_empty !== 1'b1 || bus.stack_err !== 1'b1) begin
      bad++;
      $display("FAIL ret_empty e=%b err=%b exp 1 1",
               bus.stack_empty, bus.stack_err);
    end
`else
    tick(1'b1, 2'b01, 5'h10, 1'b0, 1'b1);
    total++;
    if (bus.pc !== 8'h70 || bus.stack_full !== 1'b0 ||
        bus.stack_empty !== 1'b1) begin
      bad++;
      $display("FAIL nostk_call pc=%h f=%b e=%b exp 70 0 1",
               bus.pc, bus.stack_full, bus.stack_empty);
    end
    tick(1'b1, 2'b11, 5'h00, 1'b0, 1'b0);
    total++;
    if (bus.pc !== 8'h71 || bus.stack_err !== 1'b0) begin
      bad++;
      $display("FAIL nostk_ret pc=%h err=%b exp 71 0",
               bus.pc, bus.stack_err);
    end
`endif
  endtask

  task automatic test_underflow();
    logic exp_err;
`ifdef CALL_STACK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    goto_pc(8'h30);
    tick(1'b1, 2'b11, 5'h00, 1'b0, 1'b0);
    total++;
    if (bus.pc !== 8'h31 || bus.stack_err !== exp_err) begin
      bad++;
      $display("FAIL underflow pc=%h err=%b exp 31 %b",
               bus.pc, bus.stack_err, exp_err);
    end
    tick(1'b1, 2'b00, 5'h00, 1'b0, 1'b0);
    tick(1'b0, 2'b00, 5'h00, 1'b0, 1'b0);
    tick(1'b1, 2'b01, 5'h05, 1'b0, 1'b0);
    total++;
    if (bus.pc !== 8'h25 || bus.stack_err !== exp_err) begin
      bad++;
      $display("FAIL err_sticky pc=%h err=%b exp 25 %b",
               bus.pc, bus.stack_err, exp_err);
    end
    do_reset();
    total++;
    if (bus.stack_err !== 1'b0) begin
      bad++; $display("FAIL err_clear err=%b exp 0", bus.stack_err);
    end
  endtask

  task automatic test_hold();
    logic exp_e;
    logic [7:0] exp_ret;
`ifdef CALL_STACK_EN
    exp_e = 1'b0; exp_ret = 8'h24;
`else
    exp_e = 1'b1; exp_ret = 8'h29;
`endif
    do_reset();
    goto_pc(8'h23);
    tick(1'b1, 2'b01, 5'h08, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 2'b11, 5'h1F, 1'b1, 1'b1);
      total++;
      if (bus.pc !== 8'h28 || bus.stack_empty !== exp_e) begin
        bad++;
        $display("FAIL hold%0d pc=%h e=%b exp 28 %b",
                 i, bus.pc, bus.stack_empty, exp_e);
      end
    end
    tick(1'b1, 2'b11, 5'h00, 1'b0, 1'b0);
    total++;
    if (bus.pc !== exp_ret) begin
      bad++;
      $display("FAIL hold_ret pc=%h exp=%h", bus.pc, exp_ret);
    end
    tick(1'b1, 2'b01, 5'h00, 1'b0, 1'b1);
    total++;
    if (bus.pc !== 8'h20) begin
      bad++; $display("FAIL pre_rst pc=%h exp=20", bus.pc);
    end
    rst = 1'b1;
    tick(1'b1, 2'b01, 5'h1F, 1'b0, 1'b1);
    rst = 1'b0;
    total++;
    if (bus.pc !== 8'h00 || bus.stack_empty !== 1'b1 ||
        bus.stack_full !== 1'b0) begin
      bad++;
      $display("FAIL rst_prio pc=%h e=%b f=%b exp 00 1 0",
               bus.pc, bus.stack_empty, bus.stack_full);
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.op = 2'b00; bus.target = 5'h00;
    bus.br_taken = 1'b0; bus.call = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_inc();
    test_jmp();
    test_br();
    test_calls();
    test_underflow();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
